// File: rtl/fetch_unit.sv
// fetch_unit: decoupled instruction fetch; sequential PCs to imem, returned words buffered with their PCs for decode.
// Latency: a response is visible on if_valid the cycle after imem_rvalid; one instruction per cycle in steady state.
// Backpressure: FIFO entries plus in-flight requests never exceed DEPTH, so imem_req drops while decode stalls.
//
// Ports:
//   clk, areset                  - rising-edge clock, synchronous active-high reset
//   redirect, redirect_pc        - restart fetch at redirect_pc (low two bits forced to zero)
//   imem_req/addr/gnt            - request channel to instruction memory (addr held until granted)
//   imem_rvalid, imem_rdata      - in-order response channel from instruction memory
//   if_valid/ready, if_instr/pc  - valid/ready hand-off of the FIFO head to decode

// fetch_fifo: DEPTH-entry FIFO with synchronous flush.
// Latency: a pushed entry is visible at the head the following cycle.
// Backpressure: a push is accepted while not full, or when full if a pop happens in the same cycle.
module fetch_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             areset,
    input  logic             flush,
    input  logic             push_vld,
    input  logic [W-1:0]     push_dat,
    output logic             pop_vld,
    input  logic             pop_rdy,
    output logic [W-1:0]     pop_dat,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;
    logic             pop;

    assign pop_vld = (count != '0);
    assign pop     = pop_vld && pop_rdy;
    // A simultaneous pop frees the head slot, so a push into a full FIFO still proceeds.
    assign push    = push_vld && ((count != CNT_W'(DEPTH)) || pop);
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (areset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= push_dat;
        end
    end
endmodule

module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 4
) (
    input  logic            clk,
    input  logic            areset,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [31:0]     if_instr,
    output logic [XLEN-1:0] if_pc
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int SUM_W = CNT_W + 1;

    logic [XLEN-1:0]    fetch_pc;
    logic [XLEN-1:0]    resp_pc;
    logic [CNT_W-1:0]   outstanding;
    logic [CNT_W-1:0]   discard;
    logic [CNT_W-1:0]   fifo_count;
    logic               fifo_vld;
    logic [XLEN+31:0]   fifo_dat;
    logic [XLEN-1:0]    target_pc;
    logic [SUM_W-1:0]   credits_used;
    logic               grant;
    logic               push;
    logic               redirect_pc_unused;

    assign target_pc          = {redirect_pc[XLEN-1:2], 2'b00};
    assign redirect_pc_unused = ^redirect_pc[1:0];

    // Credits cover both buffered entries and requests still in flight, so every response has a slot.
    assign credits_used = {1'b0, fifo_count} + {1'b0, outstanding};
    assign imem_req     = !areset && !redirect && (credits_used < SUM_W'(DEPTH));
    assign imem_addr    = fetch_pc;
    assign grant        = imem_req && imem_gnt;

    // Responses owed to a pre-redirect PC stream are dropped until discard drains.
    assign push     = imem_rvalid && (discard == '0) && !redirect;
    assign if_valid = fifo_vld && !redirect;
    assign if_pc    = fifo_dat[XLEN+31:32];
    assign if_instr = fifo_dat[31:0];

    fetch_fifo #(
        .W     (XLEN + 32),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk      (clk),
        .areset   (areset),
        .flush    (redirect),
        .push_vld (push),
        .push_dat ({resp_pc, imem_rdata}),
        .pop_vld  (fifo_vld),
        .pop_rdy  (if_ready && !redirect),
        .pop_dat  (fifo_dat),
        .count    (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (areset) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else if (redirect) begin
            fetch_pc    <= target_pc;
            resp_pc     <= target_pc;
            // Everything still in flight belongs to the old stream; a response landing now is dropped too.
            outstanding <= outstanding - CNT_W'(imem_rvalid);
            discard     <= outstanding - CNT_W'(imem_rvalid);
        end else begin
            if (grant) begin
                fetch_pc <= fetch_pc + XLEN'(4);
            end
            outstanding <= outstanding + CNT_W'(grant) - CNT_W'(imem_rvalid);
            if (imem_rvalid) begin
                if (discard != '0) begin
                    discard <= discard - CNT_W'(1);
                end else begin
                    resp_pc <= resp_pc + XLEN'(4);
                end
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
    localparam int          XLEN   = 32;
    localparam int          DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    typedef struct {
        int          due;
        logic [31:0] addr;
    } mem_t;

    logic        clk = 1'b0;
    logic        areset;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;

    fetch_unit #(
        .XLEN     (XLEN),
        .RESET_PC (RST_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk         (clk),
        .areset      (areset),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .if_valid    (if_valid),
        .if_ready    (if_ready),
        .if_instr    (if_instr),
        .if_pc       (if_pc)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          lat = 1;
    logic [31:0] rdata_xor = 32'h0;
    int          fire_cnt = 0;
    int          rsp_cnt = 0;
    int          grant_limit = 0;
    int          redir_seq = 0;
    int          redir_ack = 0;
    int          redir_mode = 0;
    int          redir_n = 0;
    int          redir_base = 0;
    logic [31:0] redir_target = 32'h0;
    exp_t        exp_q[$];
    mem_t        mem_q[$];
    int          pop_cyc_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: wait bound expired, required event did not occur", name);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic push_exp(input logic [31:0] pc0, input int n);
        for (int k = 0; k < n; k++) begin
            exp_t e;
            e.pc    = pc0 + 32'(4 * k);
            e.instr = e.pc ^ rdata_xor;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_drain(input string name, input int max);
        bit done = 1'b0;
        for (int i = 0; i < max && !done; i++) begin
            if (exp_q.size() == 0 && mem_q.size() == 0 && fire_cnt >= grant_limit) done = 1'b1;
            else tick(1);
        end
        if (!done) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s: drain bound expired, %0d outputs pending, required 0", name, exp_q.size());
        end
        tick(2);
    endtask

    // Instruction memory: in-order responses `lat` cycles after grant, rdata = addr ^ rdata_xor.
    // Also the single driver of redirect, sequenced by commands from the stimulus process.
    initial begin
        bit present;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        forever begin
            @(negedge clk);
            if (!areset) begin
                if (imem_req && imem_gnt) begin
                    mem_t m;
                    m.due  = cyc + lat;
                    m.addr = imem_addr;
                    mem_q.push_back(m);
                    fire_cnt++;
                end
                if (imem_rvalid) begin
                    mem_q.delete(0);
                    rsp_cnt++;
                end
            end
            @(posedge clk);
            #1;
            cyc++;
            if (areset) mem_q.delete();
            present     = !areset && mem_q.size() > 0 && mem_q[0].due <= cyc;
            imem_rvalid = present;
            imem_rdata  = present ? (mem_q[0].addr ^ rdata_xor) : 32'h0;
            redirect    = 1'b0;
            if (redir_seq != redir_ack && !areset) begin
                if (redir_mode == 1 || (present && (rsp_cnt - redir_base) == redir_n)) begin
                    redirect    = 1'b1;
                    redirect_pc = redir_target;
                    redir_ack   = redir_seq;
                end
            end
            imem_gnt = !areset && (fire_cnt < grant_limit);
        end
    end

    // Monitor: pops the scoreboard on every decode hand-off and checks redirect-cycle outputs.
    initial begin
        bit          prev_hold = 1'b0;
        logic [31:0] prev_addr = 32'h0;
        forever begin
            @(negedge clk);
            if (areset) begin
                prev_hold = 1'b0;
            end else begin
                if (if_valid && if_ready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_output: got pc %h instr %h, required no output", if_pc, if_instr);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        chk("if_pc", if_pc, e.pc);
                        chk("if_instr", if_instr, e.instr);
                        pop_cyc_q.push_back(cyc);
                    end
                end
                if (redirect) begin
                    chk("redirect_if_valid", 32'(if_valid), 32'd0);
                    chk("redirect_imem_req", 32'(imem_req), 32'd0);
                end
                if (prev_hold && imem_req && !redirect) chk("addr_held", imem_addr, prev_addr);
                prev_hold = imem_req && !imem_gnt && !redirect;
                prev_addr = imem_addr;
            end
        end
    end

    initial begin
        #400000;
        n_fail++;
        $display("FAIL watchdog: time limit reached, required completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        int t;
        areset   = 1'b1;
        if_ready = 1'b0;

        // Reset state
        tick(3);
        chk("rst_imem_req", 32'(imem_req), 32'd0);
        chk("rst_if_valid", 32'(if_valid), 32'd0);
        areset = 1'b0;
        #1;
        chk("first_req", 32'(imem_req), 32'd1);
        chk("first_addr", imem_addr, RST_PC);

        // Streaming from RESET_PC across the 2^32 wrap, one instruction per cycle
        lat       = 1;
        rdata_xor = 32'h0;
        base      = pop_cyc_q.size();
        push_exp(RST_PC, 8);
        if_ready    = 1'b1;
        grant_limit = fire_cnt + 8;
        wait_drain("stream", 200);
        if (pop_cyc_q.size() >= base + 8) chk("stream_rate", 32'(pop_cyc_q[base + 7] - pop_cyc_q[base]), 32'd7);
        else timeout_fail("stream_rate");

        // Decode stall: exactly DEPTH grants, then drain in order and resume
        if_ready = 1'b0;
        tick(1);
        base        = fire_cnt;
        grant_limit = fire_cnt + 8;
        push_exp(32'h18, 8);
        tick(12);
        chk("stall_grants", 32'(fire_cnt - base), 32'd4);
        chk("stall_imem_req", 32'(imem_req), 32'd0);
        chk("stall_if_valid", 32'(if_valid), 32'd1);
        chk("stall_if_pc", if_pc, 32'h18);
        if_ready = 1'b1;
        wait_drain("stall_drain", 200);

        // Redirect with two slow requests in flight: both responses discarded
        lat         = 4;
        rdata_xor   = 32'hDEAD_0000;
        grant_limit = fire_cnt + 2;
        for (t = 0; t < 50 && fire_cnt < grant_limit; t++) tick(1);
        if (t >= 50) timeout_fail("p4_grants");
        redir_mode   = 1;
        redir_target = 32'h100;
        grant_limit  = fire_cnt + 2;
        push_exp(32'h100, 2);
        redir_seq++;
        for (t = 0; t < 50 && redir_ack != redir_seq; t++) tick(1);
        if (t >= 50) timeout_fail("p4_redirect");
        tick(1);
        chk("p4_discard_after", 32'(dut.discard), 32'd2);
        wait_drain("p4_drain", 200);
        chk("p4_discard_end", 32'(dut.discard), 32'd0);
        chk("p4_outstanding_end", 32'(dut.outstanding), 32'd0);

        // Redirect coinciding with a response while all credits are used; low PC bits ignored
        lat      = 1;
        if_ready = 1'b0;
        tick(1);
        redir_base   = rsp_cnt;
        redir_n      = 3;
        redir_mode   = 2;
        redir_target = 32'h203;
        grant_limit  = fire_cnt + 4;
        redir_seq++;
        for (t = 0; t < 50 && redir_ack != redir_seq; t++) tick(1);
        if (t >= 50) timeout_fail("p5_redirect");
        chk("p5_fifo_count_at_redirect", 32'(dut.fifo_count), 32'd3);
        chk("p5_outstanding_at_redirect", 32'(dut.outstanding), 32'd1);
        tick(1);
        chk("p5_if_valid", 32'(if_valid), 32'd0);
        chk("p5_fifo_count", 32'(dut.fifo_count), 32'd0);
        chk("p5_outstanding", 32'(dut.outstanding), 32'd0);
        chk("p5_discard", 32'(dut.discard), 32'd0);
        chk("p5_imem_req", 32'(imem_req), 32'd1);
        chk("p5_imem_addr", imem_addr, 32'h200);
        push_exp(32'h200, 2);
        grant_limit = fire_cnt + 2;
        if_ready    = 1'b1;
        wait_drain("p5_drain", 200);

        // Reset mid-transaction: two entries buffered, two requests in flight
        lat      = 3;
        if_ready = 1'b0;
        tick(1);
        base        = rsp_cnt;
        grant_limit = fire_cnt + 4;
        for (t = 0; t < 50 && (rsp_cnt - base) < 2; t++) tick(1);
        if (t >= 50) timeout_fail("p6_responses");
        chk("p6_fifo_count_pre", 32'(dut.fifo_count), 32'd2);
        chk("p6_outstanding_pre", 32'(dut.outstanding), 32'd2);
        areset = 1'b1;
        tick(1);
        chk("p6_if_valid", 32'(if_valid), 32'd0);
        chk("p6_imem_req", 32'(imem_req), 32'd0);
        chk("p6_fifo_count", 32'(dut.fifo_count), 32'd0);
        chk("p6_outstanding", 32'(dut.outstanding), 32'd0);
        chk("p6_discard", 32'(dut.discard), 32'd0);
        areset = 1'b0;
        #1;
        chk("p6_imem_req_release", 32'(imem_req), 32'd1);
        chk("p6_imem_addr_release", imem_addr, RST_PC);
        push_exp(RST_PC, 3);
        grant_limit = fire_cnt + 3;
        if_ready    = 1'b1;
        wait_drain("p6_drain", 200);

        tick(5);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
